// File: rtl/imm_pkg.sv
// Shared types for the immediate decode stage: RV32I opcodes, the format
// enum and the decoded register-field bundle carried through the stage.
package imm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Register/opcode fields of one decoded instruction; imm/target are
    // XLEN-dependent and therefore live beside this struct in the stage.
    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        logic       illegal;
    } fields_t;

    // Unknown opcodes map to FMT_R so their register fields pass through raw.
    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
            OP_STORE:                            return FMT_S;
            OP_BRANCH:                           return FMT_B;
            OP_LUI, OP_AUIPC:                    return FMT_U;
            OP_JAL:                              return FMT_J;
            default:                             return FMT_R;
        endcase
    endfunction

    function automatic logic opcode_illegal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM,
            OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b0;
            default:                                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational field splitter and immediate generator for one instruction.
// Produces the full decoded entry (fields, sign-extended imm, branch target).
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output fields_t         fields_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o
);

    fmt_e        fmt;
    logic [31:0] imm32;

    // Select fields and build the 32-bit immediate according to the format.
    always_comb begin
        fmt              = opcode_fmt(instr_i[6:0]);
        fields_o         = '0;
        imm32            = '0;
        fields_o.fmt     = fmt;
        fields_o.opcode  = instr_i[6:0];
        fields_o.illegal = opcode_illegal(instr_i[6:0]);
        case (fmt)
            FMT_R: begin
                fields_o.rd     = instr_i[11:7];
                fields_o.funct3 = instr_i[14:12];
                fields_o.rs1    = instr_i[19:15];
                fields_o.rs2    = instr_i[24:20];
                fields_o.funct7 = instr_i[31:25];
            end
            FMT_I: begin
                fields_o.rd     = instr_i[11:7];
                fields_o.funct3 = instr_i[14:12];
                fields_o.rs1    = instr_i[19:15];
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            FMT_S: begin
                fields_o.funct3 = instr_i[14:12];
                fields_o.rs1    = instr_i[19:15];
                fields_o.rs2    = instr_i[24:20];
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            FMT_B: begin
                fields_o.funct3 = instr_i[14:12];
                fields_o.rs1    = instr_i[19:15];
                fields_o.rs2    = instr_i[24:20];
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            FMT_U: begin
                fields_o.rd = instr_i[11:7];
                imm32 = {instr_i[31:12], 12'b0};
            end
            FMT_J: begin
                fields_o.rd = instr_i[11:7];
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Every immediate is already sign-correct at 32 bits; widen by sign.
    assign imm_o    = XLEN'($signed(imm32));
    // Only branches and jumps get a precomputed pc-relative target.
    assign target_o = (fmt == FMT_B || fmt == FMT_J) ? (pc_i + imm_o) : '0;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: extracts fields at the input, then holds decoded
// entries in a main register plus an optional skid register.
// Handshake: a side transfers on a rising edge where valid && ready are both
// high; a producer holds valid and data until that edge, and the stage holds
// out_* stable while out_valid && !out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output fmt_e            out_fmt,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef struct packed {
        logic            valid;
        fields_t         f;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } entry_t;

    fields_t         in_fields;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_target;
    entry_t          in_entry;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic            push;
    logic            pop;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .fields_o (in_fields),
        .imm_o    (in_imm),
        .target_o (in_target)
    );

    assign in_entry = '{valid: 1'b1, f: in_fields, imm: in_imm, target: in_target};

    // With a skid slot, acceptance depends only on registered state; without
    // one, the single register can refill in the cycle it drains.
    assign in_ready = !rst && (SKID_EN ? !skid_q.valid : (!main_q.valid || out_ready));
    assign push     = in_valid && in_ready;
    assign pop      = main_q.valid && out_ready;

    // Next-state for the two-entry FIFO; the skid only fills when main stalls.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (pop) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (push) begin
                main_d = in_entry;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (push) begin
            if (!main_q.valid) begin
                main_d = in_entry;
            end else begin
                skid_d = in_entry;
            end
        end
    end

    // Entry registers; reset zeroes every held field, not just the valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_valid   = main_q.valid;
    assign out_fmt     = main_q.f.fmt;
    assign out_opcode  = main_q.f.opcode;
    assign out_rd      = main_q.f.rd;
    assign out_funct3  = main_q.f.funct3;
    assign out_rs1     = main_q.f.rs1;
    assign out_rs2     = main_q.f.rs2;
    assign out_funct7  = main_q.f.funct7;
    assign out_imm     = main_q.imm;
    assign out_target  = main_q.target;
    assign out_illegal = main_q.f.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed spec vectors on XLEN=32 and XLEN=64
// instances, handshake scenarios, and a randomized stream scored against a
// reference model built from the instruction-format rules.
`timescale 1ns/1ps
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    fmt_e        out_fmt;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;

    logic        flush_64, in_valid_64, in_ready_64, out_valid_64, out_ready_64, out_illegal_64;
    logic [31:0] in_instr_64;
    logic [63:0] in_pc_64, out_imm_64, out_target_64;
    fmt_e        out_fmt_64;
    logic [6:0]  out_opcode_64, out_funct7_64;
    logic [4:0]  out_rd_64, out_rs1_64, out_rs2_64;
    logic [2:0]  out_funct3_64;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic        illegal;
        logic [63:0] imm;
        logic [63:0] target;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    imm_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_fmt(out_fmt), .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush_64), .in_valid(in_valid_64), .in_ready(in_ready_64),
        .in_instr(in_instr_64), .in_pc(in_pc_64), .out_valid(out_valid_64), .out_ready(out_ready_64),
        .out_fmt(out_fmt_64), .out_opcode(out_opcode_64), .out_rd(out_rd_64), .out_funct3(out_funct3_64),
        .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_funct7(out_funct7_64), .out_imm(out_imm_64),
        .out_target(out_target_64), .out_illegal(out_illegal_64)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Immediates are computed as signed integers from weighted instruction
    // bits, then truncated to the datapath width.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t   e;
        longint v;
        e        = '0;
        e.opcode = ins[6:0];
        case (ins[6:0])
            7'b0110011:                                     e.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.fmt = FMT_I;
            7'b0100011:                                     e.fmt = FMT_S;
            7'b1100011:                                     e.fmt = FMT_B;
            7'b0110111, 7'b0010111:                         e.fmt = FMT_U;
            7'b1101111:                                     e.fmt = FMT_J;
            default: begin e.fmt = FMT_R; e.illegal = 1'b1; end
        endcase
        e.rd     = (e.fmt == FMT_S || e.fmt == FMT_B) ? 5'd0 : ins[11:7];
        e.funct3 = (e.fmt == FMT_U || e.fmt == FMT_J) ? 3'd0 : ins[14:12];
        e.rs1    = (e.fmt == FMT_U || e.fmt == FMT_J) ? 5'd0 : ins[19:15];
        e.rs2    = (e.fmt == FMT_R || e.fmt == FMT_S || e.fmt == FMT_B) ? ins[24:20] : 5'd0;
        e.funct7 = (e.fmt == FMT_R) ? ins[31:25] : 7'd0;
        v = 0;
        case (e.fmt)
            FMT_I: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
            FMT_S: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd4096 : 64'sd0);
            FMT_B: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                       - (ins[31] ? 64'sd4096 : 64'sd0);
            FMT_U: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
            FMT_J: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
                       - (ins[31] ? 64'sd1048576 : 64'sd0);
            default: v = 0;
        endcase
        e.imm = 64'(v);
        if (e.fmt == FMT_B || e.fmt == FMT_J) e.target = pc + 64'(v);
        if (xlen == 32) begin
            e.imm[63:32]    = '0;
            e.target[63:32] = '0;
        end
        return e;
    endfunction

    function automatic exp_t obs32();
        exp_t o;
        o.fmt = out_fmt;  o.opcode = out_opcode; o.rd = out_rd; o.funct3 = out_funct3;
        o.rs1 = out_rs1;  o.rs2 = out_rs2; o.funct7 = out_funct7; o.illegal = out_illegal;
        o.imm = {32'b0, out_imm}; o.target = {32'b0, out_target};
        return o;
    endfunction

    function automatic logic [31:0] mk_addi(input int k);
        return {12'(k), 5'd0, 3'd0, 5'(k), 7'b0010011};
    endfunction

    // ---------------- drivers ----------------
    task automatic clean();
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic rand_instr();
        logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                  7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        logic [31:0] r;
        logic [31:0] p;
        int          idx;
        r   = $urandom();
        p   = $urandom();
        idx = $urandom_range(0, 11);
        in_instr = (idx < 10) ? {r[31:7], ops[idx]} : r;
        in_pc    = {p[31:2], 2'b00};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [119:0] all_out;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        flush_64 = 1'b0; in_valid_64 = 1'b0; in_instr_64 = '0; in_pc_64 = '0; out_ready_64 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || in_ready_64 !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b/%b need 0/0", in_ready, in_ready_64);
        end
        all_out = {out_valid, out_fmt, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
                   out_imm, out_target, out_illegal};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h need 0", all_out);
        end
        checks++;
        if (out_valid_64 !== 1'b0 || out_imm_64 !== 64'd0 || out_target_64 !== 64'd0) begin
            errors++; $display("FAIL reset_outputs_64: valid=%b imm=%h target=%h need zeros",
                               out_valid_64, out_imm_64, out_target_64);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_reset: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_instr [6] = '{32'hFE000EE3, 32'hFFF00093, 32'h123452B7,
                                     32'h0021A623, 32'h008000EF, 32'h00000000};
        logic [31:0] d_pc    [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204};
        fmt_e        d_fmt   [6] = '{FMT_B, FMT_I, FMT_U, FMT_S, FMT_J, FMT_R};
        logic [31:0] d_imm   [6] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 32'h12345000, 32'd12, 32'd8, 32'd0};
        logic [31:0] d_tgt   [6] = '{32'h000000FC, 32'd0, 32'd0, 32'd0, 32'h208, 32'd0};
        logic [4:0]  d_rd    [6] = '{5'd0, 5'd1, 5'd5, 5'd0, 5'd1, 5'd0};
        logic [4:0]  d_rs1   [6] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
        logic [4:0]  d_rs2   [6] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
        logic        d_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [83:0] got, want;
        for (int i = 0; i < 6; i++) begin
            clean();
            in_valid = 1'b1; in_instr = d_instr[i]; in_pc = d_pc[i]; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            got  = {out_valid, out_fmt, out_imm, out_target, out_rd, out_rs1, out_rs2, out_illegal};
            want = {1'b1, d_fmt[i], d_imm[i], d_tgt[i], d_rd[i], d_rs1[i], d_rs2[i], d_ill[i]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL directed_%0d instr=%h: got v/fmt/imm/tgt/rd/rs1/rs2/ill=%h need %h",
                         i, d_instr[i], got, want);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        clean();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk_addi(1); in_pc = 32'h0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: in_ready=%b need 1", in_ready); end
        @(posedge clk); #1;
        in_instr = mk_addi(2);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd1) begin
            errors++; $display("FAIL bp_accept_b: in_ready=%b valid=%b rd=%0d need 1/1/1", in_ready, out_valid, out_rd);
        end
        @(posedge clk); #1;
        in_instr = mk_addi(3);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_full: in_ready=%b need 0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1 || out_imm !== 32'd1) begin
            errors++; $display("FAIL bp_hold: in_ready=%b valid=%b rd=%0d imm=%h need 0/1/1/1",
                               in_ready, out_valid, out_rd, out_imm);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_rd !== 5'(k + 1) || out_imm !== 32'(k + 1)) begin
                errors++; $display("FAIL bp_release_%0d: valid=%b rd=%0d imm=%h need 1/%0d/%0d",
                                   k, out_valid, out_rd, out_imm, k + 1, k + 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained: out_valid=%b in_valid=%b need 0/0", out_valid, in_valid);
        end
    endtask

    task automatic test_flush();
        logic seen;
        clean();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk_addi(11); in_pc = 32'h0;
        @(posedge clk); #1;
        in_instr = mk_addi(12);
        @(posedge clk); #1;
        in_instr = mk_addi(13); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = mk_addi(14); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_drop: out_valid seen=%b need 0", seen); end
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = mk_addi(15);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd15) begin
            errors++; $display("FAIL flush_resume: valid=%b rd=%0d need 1/15", out_valid, out_rd);
        end
    endtask

    task automatic test_rst_mid_stall();
        logic [119:0] all_out;
        clean();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h800002B7; in_pc = 32'h40;
        @(posedge clk); #1;
        in_instr = 32'hFE000EE3;
        @(posedge clk); #1;
        in_instr = mk_addi(7); rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        all_out = {out_valid, out_fmt, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
                   out_imm, out_target, out_illegal};
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rst_stall_outputs: got %h need 0", all_out); end
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        logic pending;
        exp_t e, o;
        clean();
        pending = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pending) begin
                if (cyc < 390 && $urandom_range(0, 9) < 7) begin
                    rand_instr(); in_valid = 1'b1; pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (cyc >= 390) ? 1'b1 : ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_output: cycle %0d rd=%0d imm=%h", cyc, out_rd, out_imm);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    o = obs32();
                    if (o !== e) begin
                        errors++; $display("FAIL rand_entry cycle %0d: got %h need %h", cyc, o, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_instr, {32'b0, in_pc}, 32));
                pending = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain: %0d entries missing, out_valid=%b", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] v_instr [3] = '{32'hFFDFF0EF, 32'hFE000EE3, 32'h800002B7};
        logic [63:0] v_pc    [3] = '{64'h200, 64'h1_0000_0000, 64'h300};
        fmt_e        v_fmt   [3] = '{FMT_J, FMT_B, FMT_U};
        logic [63:0] v_imm   [3] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000};
        logic [63:0] v_tgt   [3] = '{64'h1FC, 64'hFFFFFFFC, 64'h0};
        logic [4:0]  v_rd    [3] = '{5'd1, 5'd0, 5'd5};
        logic [136:0] got, want;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid_64 = 1'b1; in_instr_64 = v_instr[i]; in_pc_64 = v_pc[i];
            @(posedge clk); #1;
            in_valid_64 = 1'b0;
            @(negedge clk);
            got  = {out_valid_64, out_fmt_64, out_imm_64, out_target_64, out_rd_64, out_illegal_64};
            want = {1'b1, v_fmt[i], v_imm[i], v_tgt[i], v_rd[i], 1'b0};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL xlen64_%0d instr=%h: got %h need %h", i, v_instr[i], got, want);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_rst_mid_stall();
        test_random();
        test_xlen64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
